// File: rtl/fir_pkg.sv
// Shared types and sizes for the FIR tap sequencer and its 64-entry delay line.
package fir_pkg;

    // Sample/coefficient width, delay-line address width and delay-line depth.
    localparam int SAMPLE_W = 16;
    localparam int ADDR_W   = 6;
    localparam int DEPTH    = 64;

    // Sequencer states; encodings are fixed so they read the same in every dump.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        MAC   = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/fir_mac_sat.sv
// Signed multiply-accumulate register plus the shift/saturate that turns the
// running sum into a 16-bit output. o_y_next is the saturated result of the
// sum *including* the product presented this cycle, so the caller can register
// the final output on the same edge that adds the last tap.
module fir_mac_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 38,
    parameter int FRAC  = 15
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_en,
    input  logic signed [SAMPLE_W-1:0] i_tap,
    input  logic signed [SAMPLE_W-1:0] i_coeff,
    output logic signed [SAMPLE_W-1:0] o_y_next
);

    // Output clamp limits, held at accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-32'sd32768);

    logic signed [2*SAMPLE_W-1:0] w_prod;
    logic signed [ACC_W-1:0]      w_prod_ext;
    logic signed [ACC_W-1:0]      w_acc_next;
    logic signed [ACC_W-1:0]      w_shifted;
    logic signed [ACC_W-1:0]      r_acc;

    assign w_prod     = i_tap * i_coeff;
    assign w_prod_ext = ACC_W'(w_prod);
    // Wraps modulo 2^ACC_W; the guard bits keep 64 full-scale taps in range.
    assign w_acc_next = r_acc + w_prod_ext;
    // Arithmetic shift floors toward minus infinity.
    assign w_shifted  = w_acc_next >>> FRAC;

    // Accumulator: cleared before each sample's tap walk, adds one tap per enable.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
        end
    end

    // Clamp the scaled sum into the signed 16-bit output range.
    always_comb begin
        o_y_next = w_shifted[SAMPLE_W-1:0];
        if (w_shifted > Y_MAX) begin
            o_y_next = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (w_shifted < Y_MIN) begin
            o_y_next = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Read-side controller for the sample delay line: accepts a sample, shifts it
// into the line, walks taps 0..NTAPS-1 through the MAC and presents one
// saturated FIR output with a valid/ready handshake.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = 64,
    parameter int ACC_W = 38,
    parameter int FRAC  = 15
) (
    input  logic                       clk,
    input  logic                       R,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_data,
    input  logic                       flush,
    output logic signed [SAMPLE_W-1:0] fifo_w,
    output logic                       fifo_e,
    output logic                       fifo_r,
    output logic [ADDR_W-1:0]          fifo_addr,
    input  logic signed [SAMPLE_W-1:0] fifo_q,
    output logic [ADDR_W-1:0]          coeff_addr,
    input  logic signed [SAMPLE_W-1:0] coeff_data,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic signed [SAMPLE_W-1:0] y_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTAPS - 1);

    state_t                       r_state;
    logic signed [SAMPLE_W-1:0]   r_sample;
    logic [ADDR_W-1:0]            r_addr;
    logic signed [SAMPLE_W-1:0]   r_y_data;
    logic                         r_y_valid;
    logic                         r_fifo_e;
    logic                         r_fifo_r;
    logic                         w_last_tap;
    logic signed [SAMPLE_W-1:0]   w_y_next;

    assign w_last_tap = (r_addr == LAST_ADDR);

    // Flush wins over a coincident sample, so the source sees no ready that cycle.
    assign in_ready   = (r_state == IDLE) && !flush;
    assign fifo_w     = r_sample;
    assign fifo_e     = r_fifo_e;
    assign fifo_r     = r_fifo_r;
    assign fifo_addr  = r_addr;
    assign coeff_addr = r_addr;
    assign y_valid    = r_y_valid;
    assign y_data     = r_y_data;

    fir_mac_sat #(
        .ACC_W (ACC_W),
        .FRAC  (FRAC)
    ) u_mac (
        .clk      (clk),
        .i_rst    (R),
        .i_clr    (r_state == SHIFT),
        .i_en     (r_state == MAC),
        .i_tap    (fifo_q),
        .i_coeff  (coeff_data),
        .o_y_next (w_y_next)
    );

    // Sequencer FSM with registered strobes, tap address and output sample.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state   <= IDLE;
            r_sample  <= '0;
            r_addr    <= '0;
            r_y_data  <= '0;
            r_y_valid <= 1'b0;
            r_fifo_e  <= 1'b0;
            r_fifo_r  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_fifo_r <= 1'b1;
                        r_state  <= CLEAR;
                    end else if (in_valid) begin
                        r_sample <= in_data;
                        r_fifo_e <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                CLEAR: begin
                    r_fifo_r <= 1'b0;
                    r_state  <= IDLE;
                end
                SHIFT: begin
                    r_fifo_e <= 1'b0;
                    r_addr   <= '0;
                    r_state  <= MAC;
                end
                MAC: begin
                    // The last tap's product is folded in via w_y_next, so the
                    // output is captured on the same edge as the final add.
                    if (w_last_tap) begin
                        r_y_data  <= w_y_next;
                        r_y_valid <= 1'b1;
                        r_state   <= HOLD;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                HOLD: begin
                    if (y_ready) begin
                        r_y_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
